// File: rtl/debug_scan_pkg.sv
// Shared types and constants for the virtual-JTAG debug scan master.
// Phase lengths are counted in tck cycles.
package debug_scan_pkg;

  localparam int DR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;
  localparam int TCK_DIV_DEF  = 2;

  localparam int UIR_TCKS = 1;
  localparam int CDR_TCKS = 1;
  localparam int UDR_TCKS = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UIR   = 3'd1,
    S_CDR   = 3'd2,
    S_SHIFT = 3'd3,
    S_UDR   = 3'd4,
    S_RSP   = 3'd5
  } scan_state_e;

  // Number of tck cycles a scan state occupies; IDLE/RSP are not tck-timed.
  function automatic int phase_tcks(input scan_state_e s, input int dr_width);
    case (s)
      S_UIR:   return UIR_TCKS;
      S_CDR:   return CDR_TCKS;
      S_SHIFT: return dr_width;
      S_UDR:   return UDR_TCKS;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/debug_scan_tck_gen.sv
// Scan clock divider: tck low for TCK_DIV clk, then high for TCK_DIV clk.
// tck_fall/tck_rise are single-clk pulses marking the clk edge where tck changes.
module debug_scan_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int PERIOD = 2 * TCK_DIV;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q;

  // The first enabled clk always starts a low phase.
  assign tck_fall = en && (cnt_q == '0);
  assign tck_rise = en && (cnt_q == CW'(TCK_DIV));

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(PERIOD - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !en || tck_fall) begin
      tck <= 1'b0;
    end else if (tck_rise) begin
      tck <= 1'b1;
    end
  end

endmodule

// File: rtl/debug_scan_master.sv
// Host-side virtual-JTAG scan master: one IR+DR command in, captured DR out.
// Generates tck and the uir/cdr/sdr/udr/rti strobes for the debug module.
module debug_scan_master
  import debug_scan_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = TCK_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic                busy,
  output scan_state_e         dbg_state
);

  // Handshakes: a transfer happens on a clk edge where valid && ready; the
  // producer holds valid and payload stable until then, ready never waits on valid.

  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  scan_state_e state_q, state_d;

  logic                started_q;
  logic [BW-1:0]       tck_cnt_q;
  logic [BW-1:0]       phase_last;
  logic                phase_done;
  logic [DR_WIDTH-1:0] sr_q;
  logic [IR_WIDTH-1:0] ir_lat_q;
  logic [IR_WIDTH-1:0] ir_shadow_q;
  logic                ir_valid_q;

  logic tck_en, tck_rise, tck_fall;
  logic cmd_fire, rsp_fire;

  logic uir_d, cdr_d, sdr_d, udr_d, rti_d, tdi_d;

  assign cmd_fire   = cmd_valid && (state_q == S_IDLE);
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign tck_en     = (state_q != S_IDLE) && (state_q != S_RSP);
  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

  debug_scan_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (tck_en),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  // The first fall after a command only opens the first phase; later falls close one.
  assign phase_last = BW'(phase_tcks(state_q, DR_WIDTH) - 1);
  assign phase_done = tck_fall && started_q && (tck_cnt_q == phase_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          state_d = (!ir_valid_q || (cmd_ir != ir_shadow_q)) ? S_UIR : S_CDR;
        end
      end
      S_UIR:   if (phase_done) state_d = S_CDR;
      S_CDR:   if (phase_done) state_d = S_SHIFT;
      S_SHIFT: if (phase_done) state_d = S_UDR;
      S_UDR:   if (phase_done) state_d = S_RSP;
      S_RSP:   if (rsp_fire)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe levels for the tck cycle that begins at this fall.
  always_comb begin
    uir_d = (state_d == S_UIR);
    cdr_d = (state_d == S_CDR);
    sdr_d = (state_d == S_SHIFT);
    udr_d = (state_d == S_UDR);
    rti_d = (state_d == S_RSP);
    tdi_d = (state_d == S_SHIFT) ? sr_q[0] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      started_q <= 1'b0;
      tck_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE) begin
        started_q <= 1'b0;
      end else if (tck_fall) begin
        started_q <= 1'b1;
      end
      if (state_d != state_q) begin
        tck_cnt_q <= '0;
      end else if (tck_fall && started_q) begin
        tck_cnt_q <= tck_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q     <= '0;
      ir_lat_q <= '0;
    end else if (cmd_fire) begin
      sr_q     <= cmd_dr;
      ir_lat_q <= cmd_ir;
    end else if (tck_rise && (state_q == S_SHIFT)) begin
      sr_q <= {vji_tdo, sr_q[DR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_shadow_q <= '0;
      ir_valid_q  <= 1'b0;
      vji_ir_in   <= '0;
    end else if (tck_fall && uir_d) begin
      ir_shadow_q <= ir_lat_q;
      ir_valid_q  <= 1'b1;
      vji_ir_in   <= ir_lat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vji_uir <= 1'b0;
      vji_cdr <= 1'b0;
      vji_sdr <= 1'b0;
      vji_udr <= 1'b0;
      vji_tdi <= 1'b0;
      vji_rti <= 1'b1;
    end else if (tck_fall) begin
      vji_uir <= uir_d;
      vji_cdr <= cdr_d;
      vji_sdr <= sdr_d;
      vji_udr <= udr_d;
      vji_tdi <= tdi_d;
      vji_rti <= rti_d;
    end else if (cmd_fire) begin
      vji_rti <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
    end else if (tck_fall && (state_d == S_RSP)) begin
      rsp_valid <= 1'b1;
      rsp_dr    <= sr_q;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debug_scan_master.sv
// Bench for debug_scan_master: scoreboard of expected captures and latencies,
// plus a second instance built with TCK_DIV=1.
module tb_debug_scan_master;
  import debug_scan_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, rsp_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_dr;
  logic        cmd_ready, rsp_valid;
  logic [37:0] rsp_dr;
  logic        vji_tck, vji_tdi, tdo_drv;
  logic [1:0]  vji_ir_in;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, busy;
  scan_state_e dbg_state;

  logic        cmd_valid_f;
  logic [1:0]  cmd_ir_f;
  logic [37:0] cmd_dr_f;
  logic        cmd_ready_f, rsp_valid_f;
  logic [37:0] rsp_dr_f;
  logic        tck_f, tdi_f;
  logic [1:0]  ir_in_f;
  logic        uir_f, cdr_f, sdr_f, udr_f, rti_f, busy_f;
  scan_state_e dbg_state_f;

  // clock / reset
  always #5 clk = ~clk;

  debug_scan_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dr(rsp_dr), .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(tdo_drv),
    .vji_ir_in(vji_ir_in), .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
    .vji_udr(vji_udr), .vji_rti(vji_rti), .busy(busy), .dbg_state(dbg_state)
  );

  debug_scan_master #(.TCK_DIV(1)) dut_fast (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_f), .cmd_ready(cmd_ready_f),
    .cmd_ir(cmd_ir_f), .cmd_dr(cmd_dr_f), .rsp_valid(rsp_valid_f), .rsp_ready(1'b1),
    .rsp_dr(rsp_dr_f), .vji_tck(tck_f), .vji_tdi(tdi_f), .vji_tdo(tdi_f),
    .vji_ir_in(ir_in_f), .vji_uir(uir_f), .vji_cdr(cdr_f), .vji_sdr(sdr_f),
    .vji_udr(udr_f), .vji_rti(rti_f), .busy(busy_f), .dbg_state(dbg_state_f)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard
  logic [37:0] exp_q[$];
  int          hs_q[$];
  int          lat_q[$];

  int          edge_n = 0;
  int          uir_rises = 0, sdr_rises = 0, rsp_seen = 0, strobe_viol = 0;
  int          uir_base = 0, sdr_base = 0, rsp_base = 0;
  logic [37:0] tdi_cap = '0;
  logic        prev_tck = 1'b0, prev_rsp = 1'b0;
  logic [37:0] pop_dr;
  int          pop_hs, pop_lat;

  int          tdo_mode;
  logic [37:0] tdo_pat;
  int          tdo_idx;

  always @(posedge clk) edge_n <= edge_n + 1;

  always_comb begin
    tdo_idx = sdr_rises - sdr_base;
    if (tdo_mode == 0)      tdo_drv = vji_tdi;
    else if (tdo_mode == 1) tdo_drv = 1'b1;
    else                    tdo_drv = (tdo_idx >= 0 && tdo_idx < 38) ? tdo_pat[tdo_idx[5:0]] : 1'b0;
  end

  always @(negedge clk) begin
    if (vji_tck && !prev_tck) begin
      if (vji_uir) uir_rises++;
      if (vji_sdr) begin
        sdr_rises++;
        tdi_cap = {vji_tdi, tdi_cap[37:1]};
      end
    end
    if ((int'(vji_uir) + int'(vji_cdr) + int'(vji_udr)) > 1 || (vji_sdr && (vji_cdr || vji_udr)))
      strobe_viol++;
    if (rsp_valid && !prev_rsp) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 1, 0);
      end else begin
        pop_dr  = exp_q.pop_front();
        pop_hs  = hs_q.pop_front();
        pop_lat = lat_q.pop_front();
        check_val("rsp_dr", rsp_dr, pop_dr);
        check_val("rsp_latency", edge_n - pop_hs, pop_lat);
      end
    end
    prev_tck = vji_tck;
    prev_rsp = rsp_valid;
  end

  int   rise_f_last = 0, period_f = 0;
  logic prev_tck_f = 1'b0;
  always @(negedge clk) begin
    if (tck_f && !prev_tck_f) begin
      period_f    = edge_n - rise_f_last;
      rise_f_last = edge_n;
    end
    prev_tck_f = tck_f;
  end

  // driver tasks
  task automatic send_cmd(input logic [1:0] ir, input logic [37:0] dr,
                          input logic [37:0] exp_dr, input int lat);
    int guard = 0;
    @(negedge clk);
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check_val("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    sdr_base = sdr_rises;
    uir_base = uir_rises;
    rsp_base = rsp_seen;
    exp_q.push_back(exp_dr);
    hs_q.push_back(edge_n + 1);
    lat_q.push_back(lat);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int guard = 0;
    while (rsp_seen == rsp_base && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    check_val("rsp_arrived", 64'(rsp_seen != rsp_base), 1);
    @(negedge clk);
  endtask

  task automatic run_scan(input logic [1:0] ir, input logic [37:0] dr,
                          input logic [37:0] exp_dr, input int lat, input int exp_uir);
    send_cmd(ir, dr, exp_dr, lat);
    check_val("scan_start_flags", {busy, cmd_ready, vji_rti}, 3'b100);
    wait_rsp();
    check_val("uir_tcks", uir_rises - uir_base, exp_uir);
    check_val("sdr_tcks", sdr_rises - sdr_base, 38);
    check_val("tdi_stream", tdi_cap, dr);
    check_val("ir_in", vji_ir_in, ir);
  endtask

  task automatic check_reset();
    check_val("rst_cmd_ready", cmd_ready, 1);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_dr", rsp_dr, 0);
    check_val("rst_tck_tdi_ir", {vji_tck, vji_tdi, vji_ir_in}, 0);
    check_val("rst_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr}, 0);
    check_val("rst_rti", vji_rti, 1);
    check_val("rst_busy", busy, 0);
  endtask

  task automatic new_pattern();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    tdo_pat = r[37:0];
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [37:0] dr_r, dr_hold;
  int          hold_viol, guard, rsp_before, hs_f;

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; rsp_ready = 1'b1;
    cmd_valid_f = 1'b0; cmd_ir_f = '0; cmd_dr_f = '0;
    tdo_mode = 0; tdo_pat = '0;
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b0;
    @(negedge clk);
    check_reset();

    // loopback with a fresh IR
    tdo_mode = 0;
    run_scan(2'b01, 38'h2A_5A5A_5A5A, 38'h2A_5A5A_5A5A, 165, 1);

    // tdo tied high, IR unchanged so UIR is skipped
    tdo_mode = 1;
    run_scan(2'b01, 38'h0, 38'h3F_FFFF_FFFF, 161, 0);

    // random tdo patterns: IR change, repeat, change again
    tdo_mode = 2;
    for (int i = 0; i < 3; i++) begin
      new_pattern();
      dr_r = {$urandom_range(63, 0), $urandom()};
      run_scan((i < 2) ? 2'b10 : 2'b11, dr_r, tdo_pat, (i == 1) ? 161 : 165, (i == 1) ? 0 : 1);
    end

    // response back-pressure
    tdo_mode = 0;
    rsp_ready = 1'b0;
    dr_hold = {$urandom_range(63, 0), $urandom()};
    send_cmd(2'b11, dr_hold, dr_hold, 161);
    guard = 0;
    while (rsp_seen == rsp_base && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    hold_viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ir = 2'b00;
      cmd_dr = ~dr_hold;
      if (!rsp_valid || rsp_dr !== dr_hold || vji_tck || cmd_ready || !busy || !vji_rti)
        hold_viol++;
    end
    check_val("hold_stable", hold_viol, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_val("release_rsp_valid", rsp_valid, 0);
    check_val("release_cmd_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    check_val("ignored_cmd_idle", busy, 0);

    // reset in the middle of SHIFT
    tdo_mode = 2;
    new_pattern();
    dr_r = {$urandom_range(63, 0), $urandom()};
    send_cmd(2'b11, dr_r, tdo_pat, 161);
    guard = 0;
    while ((sdr_rises - sdr_base) < 10 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    check_val("mid_shift_reached", 64'((sdr_rises - sdr_base) >= 10), 1);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    hs_q.delete();
    lat_q.delete();
    rsp_before = rsp_seen;
    @(negedge clk);
    check_reset();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_val("no_rsp_after_reset", rsp_seen, rsp_before);
    new_pattern();
    dr_r = {$urandom_range(63, 0), $urandom()};
    run_scan(2'b11, dr_r, tdo_pat, 165, 1);

    // TCK_DIV=1 instance, loopback
    @(negedge clk);
    check_val("fast_ready", cmd_ready_f, 1);
    cmd_ir_f = 2'b01;
    cmd_dr_f = 38'h01_0000_0001;
    cmd_valid_f = 1'b1;
    hs_f = edge_n + 1;
    @(negedge clk);
    cmd_valid_f = 1'b0;
    guard = 0;
    while (!rsp_valid_f && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check_val("fast_latency", edge_n - hs_f, 83);
    check_val("fast_rsp_dr", rsp_dr_f, 38'h01_0000_0001);
    check_val("fast_tck_period", period_f, 2);

    repeat (5) @(negedge clk);
    check_val("strobe_overlap", strobe_viol, 0);
    check_val("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_scan_master.md
Name: debug_scan_master

Overview:
Host-side driver for the 2-bit-IR / 38-bit-DR virtual-JTAG debug scan interface used by the CPU debug module. It accepts one scan command (IR value + DR payload) over a valid/ready handshake and generates tck, tdi, ir_in and the uir/cdr/sdr/udr/rti strobes. It captures the returned tdo stream and delivers it on a response handshake. It sits in the on-chip debug bridge, directly facing the debug module's scan inputs, and replaces the physical JTAG hub for in-system and simulation scan access.

Parameters:
DR_WIDTH, 38, scan data register length in bits
IR_WIDTH, 2, virtual instruction register width
TCK_DIV, 2, clk cycles per tck half-period (>=1); one tck cycle = 2*TCK_DIV clk

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept a command (high only in IDLE)
cmd_ir  in  IR_WIDTH  instruction for this scan
cmd_dr  in  DR_WIDTH  data shifted out, LSB first
rsp_valid  out  1  captured data available
rsp_ready  in  1  consumer accepts response
rsp_dr  out  DR_WIDTH  captured tdo bits, bit0 = first bit captured
vji_tck  out  1  generated scan clock
vji_tdi  out  1  serial data to target
vji_tdo  in  1  serial data from target
vji_ir_in  out  IR_WIDTH  instruction presented to target
vji_uir  out  1  update-IR strobe (one tck cycle)
vji_cdr  out  1  capture-DR state (one tck cycle)
vji_sdr  out  1  shift-DR state
vji_udr  out  1  update-DR strobe (one tck cycle)
vji_rti  out  1  run-test-idle indication
busy  out  1  scan in progress (not IDLE)

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dr=0, vji_tck=0, vji_tdi=0, vji_ir_in=0, uir/cdr/sdr/udr=0, vji_rti=1, busy=0; ir_valid shadow flag cleared.
- tck generation: divider counter runs only outside IDLE/RSP; tck low for TCK_DIV clk, then high for TCK_DIV clk. All master outputs change only at tck falling edge (start of low phase); tdo sampled on the clk where tck rises.
- States: IDLE, UIR, CDR, SHIFT, UDR, RSP.
- IDLE: cmd_ready=1, rti=1. On cmd_valid&cmd_ready: latch cmd_ir, cmd_dr into shift register sr; rti->0; go to UIR if !ir_valid or cmd_ir != ir_shadow, else to CDR.
- UIR: ir_in=cmd_ir, uir=1 for exactly one tck cycle; set ir_shadow=cmd_ir, ir_valid=1 -> CDR.
- CDR: cdr=1 for one tck cycle -> SHIFT.
- SHIFT: sdr=1 for exactly DR_WIDTH tck cycles; tdi=sr[0] during each cycle; on each tck rise, sr <= {tdo, sr[DR_WIDTH-1:1]}; bit counter 0..DR_WIDTH-1; after last rise -> UDR.
- UDR: udr=1 for one tck cycle; sdr=0; then rsp_dr<=sr, rsp_valid=1 -> RSP.
- RSP: tck held low, rti=1; hold rsp_valid/rsp_dr stable until rsp_ready; on handshake rsp_valid->0 -> IDLE (cmd_ready rises the following cycle).
- ir_in holds its last value outside UIR (target sees stable IR).
- Latency (TCK_DIV=2): handshake at clk 0; first tck low phase starts clk 1; rsp_valid high at clk 1+41*4=165 with UIR, 161 when UIR skipped.
- cmd_valid while busy: ignored, no state change (cmd_ready=0).
- Reset mid-operation: immediate return to reset values on the next clk; partial scan abandoned, no response produced, ir_valid cleared (next scan always issues UIR).
- At most one uir/cdr/udr high at any time; sdr never overlaps cdr/udr.

Decomposition:
- Package debug_scan_pkg: state enum (IDLE, UIR, CDR, SHIFT, UDR, RSP), DR_WIDTH=38, IR_WIDTH=2 defaults, phase-length constants.
- Sub-module debug_scan_tck_gen: TCK_DIV divider producing vji_tck, tck_rise and tck_fall single-clk pulses, with an enable input; the FSM/shift register stays in the top.

Test Plan:
- Loopback vji_tdo=vji_tdi, cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A -> rsp_dr=38'h2A_5A5A_5A5A; uir one tck cycle with ir_in=01; exactly 38 tck rises while sdr=1; rsp_valid at clk 165.
- tdo tied 1, cmd_dr=0 -> rsp_dr=38'h3F_FFFF_FFFF; tdi observed 0 throughout SHIFT.
- Two back-to-back commands with cmd_ir=2'b10 -> second has no uir pulse, rsp_valid 161 clk after its handshake; third with cmd_ir=2'b11 -> uir reissued.
- rsp_ready held low 20 clk after rsp_valid -> rsp_valid/rsp_dr stable, tck low, cmd_ready=0, cmd_valid ignored; release -> IDLE one clk later.
- reset asserted after 10 shift bits -> next clk all outputs at reset values, no rsp_valid; next command with previous IR still emits uir.
- TCK_DIV=1 build, loopback cmd_dr=38'h01_0000_0001 -> tck period 2 clk, rsp_dr matches, latency 1+41*2=83 clk.
